// File: rtl/dma_pkg.sv
// DMA-wide defaults and helpers shared by the DMA staging FIFO and its storage array.
package dma_pkg;

  localparam int DMA_DATA_W  = 32;
  localparam int DMA_FIFO_AW = 3;

  // Occupancy must represent 0..2**aw inclusive, hence one extra bit.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/dma_sync_fifo_if.sv
// Handshake and status bundle between a DMA engine (master) and the staging FIFO (slave).
interface dma_sync_fifo_if
  import dma_pkg::*;
#(
  parameter int DW = DMA_DATA_W,
  parameter int AW = DMA_FIFO_AW
);

  logic                    clear;
  logic                    wr;
  logic [DW-1:0]           wdata;
  logic                    rd;
  logic [DW-1:0]           rdata;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [cnt_width(AW)-1:0] count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output clear, wr, wdata, rd,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, wr, wdata, rd,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/dma_fifo_ram.sv
// Storage array for dma_sync_fifo; registered read port, or combinational when
// DMA_FIFO_FWFT_EN is defined. Contents are never reset.
module dma_fifo_ram
  import dma_pkg::*;
#(
  parameter int DW = DMA_DATA_W,
  parameter int AW = DMA_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wrEn,
  input  logic [AW-1:0] i_wrIdx,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rdEn,
  input  logic [AW-1:0] i_rdIdx,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrIdx] <= i_wdata;
    end
  end

`ifdef DMA_FIFO_FWFT_EN
  // Head entry is always presented; the read enable only moves the pointer upstream.
  logic w_unused;
  assign w_unused = &{1'b0, rst, i_rdEn};
  assign o_rdata  = r_mem[i_rdIdx];
`else
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_rdEn) begin
      r_rdata <= r_mem[i_rdIdx];
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/dma_sync_fifo.sv
// Parametrised single-clock DMA staging FIFO with exact full/empty, occupancy and sticky
// error flags. Define DMA_FIFO_FWFT_EN for first-word-fall-through read data.
module dma_sync_fifo
  import dma_pkg::*;
#(
  parameter int DW       = DMA_DATA_W,
  parameter int AW       = DMA_FIFO_AW,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input logic             clk,
  input logic             rst,
  dma_sync_fifo_if.slave  bus
);

  localparam int             CW     = cnt_width(AW);
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);

  if (AF_LEVEL > 2**AW) begin : g_afCheck
    $error("dma_sync_fifo: AF_LEVEL must not exceed the FIFO depth");
  end
  if (AE_LEVEL >= 2**AW) begin : g_aeCheck
    $error("dma_sync_fifo: AE_LEVEL must be below the FIFO depth");
  end

  logic [CW-1:0] r_wrPtr;
  logic [CW-1:0] r_rdPtr;
  logic          r_overflow;
  logic          r_underflow;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_rdAcc;
  logic          w_wrAcc;

  // Status decodes only registered pointers, so wr/rd never reach a status output.
  assign w_count = r_wrPtr - r_rdPtr;
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_empty = (r_wrPtr == r_rdPtr);

  assign w_rdAcc = bus.rd && !w_empty && !bus.clear;
  assign w_wrAcc = bus.wr && (!w_full || w_rdAcc) && !bus.clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clear) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rdAcc) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (bus.wr && !w_wrAcc) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  dma_fifo_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_wrEn  (w_wrAcc),
    .i_wrIdx (r_wrPtr[AW-1:0]),
    .i_wdata (bus.wdata),
    .i_rdEn  (w_rdAcc),
    .i_rdIdx (r_rdPtr[AW-1:0]),
    .o_rdata (bus.rdata)
  );

  assign bus.count        = w_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (w_count >= AF_CNT);
  assign bus.almost_empty = (w_count <= AE_CNT);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
